// File: rtl/ysyx_23060203_pkg.sv
// Shared types for the write-back stage: write-data select codes and the
// retire-queue entry layout.
package ysyx_23060203_pkg;

  localparam int XLEN   = 32;
  localparam int NR_REG = 16;
  localparam int RD_W   = $clog2(NR_REG);

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'd0,
    WSEL_LOAD = 2'd1,
    WSEL_PC4  = 2'd2,
    WSEL_CSR  = 2'd3
  } wsel_t;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] dnpc;
  } wb_entry_t;

  function automatic logic [NR_REG-1:0] rd_onehot(input logic [RD_W-1:0] rd);
    logic [NR_REG-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ysyx_23060203_wbu_if.sv
// Bundle of the write-back stage's upstream, register-file and commit signals.
// master = environment side, slave = the write-back unit.
interface ysyx_23060203_wbu_if;
  import ysyx_23060203_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [RD_W-1:0]   in_rd;
  wsel_t             in_wsel;
  logic [XLEN-1:0]   in_alu_val;
  logic [XLEN-1:0]   in_load;
  logic [XLEN-1:0]   in_csr_val;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_dnpc;
  logic              gpr_wen;
  logic [RD_W-1:0]   gpr_waddr;
  logic [XLEN-1:0]   gpr_wdata;
  logic              cm_valid;
  logic              cm_ready;
  logic [XLEN-1:0]   cm_dnpc;
  logic [NR_REG-1:0] busy_mask;
  logic [63:0]       retired;

  modport master (
    output in_valid, in_rd, in_wsel, in_alu_val, in_load, in_csr_val, in_pc, in_dnpc,
    output cm_ready,
    input  in_ready, gpr_wen, gpr_waddr, gpr_wdata, cm_valid, cm_dnpc, busy_mask, retired
  );

  modport slave (
    input  in_valid, in_rd, in_wsel, in_alu_val, in_load, in_csr_val, in_pc, in_dnpc,
    input  cm_ready,
    output in_ready, gpr_wen, gpr_waddr, gpr_wdata, cm_valid, cm_dnpc, busy_mask, retired
  );

endinterface

// File: rtl/ysyx_23060203_wb_fifo.sv
// In-order DEPTH-entry queue of wb_entry_t with wrap-bit pointers; also exposes
// every slot and its occupancy so the parent can build a hazard mask.
module ysyx_23060203_wb_fifo
  import ysyx_23060203_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        din,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] slot_valid,
  output wb_entry_t        slots [DEPTH]
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  wb_entry_t   mem_q [DEPTH];
  wb_entry_t   mem_d [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // A slot is live when its distance past the read pointer is below the fill count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [AW-1:0] offs;
    assign offs           = AW'(gi) - rd_ptr_q[AW-1:0];
    assign slot_valid[gi] = ({1'b0, offs} < count);
    assign slots[gi]      = mem_q[gi];
  end

endmodule

// File: rtl/ysyx_23060203_wbu.sv
// Write-back stage: selects write data at enqueue, retires one queued entry per
// accepted commit, and reports pending destination registers and a retire count.
module ysyx_23060203_wbu
  import ysyx_23060203_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  ysyx_23060203_wbu_if.slave   bus
);
  wb_entry_t         in_entry;
  wb_entry_t         head;
  wb_entry_t         slots [DEPTH];
  logic [DEPTH-1:0]  slot_valid;
  logic              push, pop, full, empty;
  logic [NR_REG-1:0] busy_mask;
  logic [63:0]       retired_q, retired_d;
  logic              unused_fields;

  always_comb begin
    in_entry      = '0;
    in_entry.rd   = bus.in_rd;
    in_entry.pc   = bus.in_pc;
    in_entry.dnpc = bus.in_dnpc;
    case (bus.in_wsel)
      WSEL_ALU:  in_entry.wdata = bus.in_alu_val;
      WSEL_LOAD: in_entry.wdata = bus.in_load;
      WSEL_PC4:  in_entry.wdata = bus.in_pc + XLEN'(4);
      default:   in_entry.wdata = bus.in_csr_val;
    endcase
  end

  // in_ready depends only on registered fill state, never on cm_ready.
  assign push = bus.in_valid & ~full;
  assign pop  = ~empty & bus.cm_ready;

  ysyx_23060203_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .din        (in_entry),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .slot_valid (slot_valid),
    .slots      (slots)
  );

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        busy_mask = busy_mask | rd_onehot(slots[i].rd);
      end
    end
    busy_mask[0] = 1'b0;
  end

  assign retired_d = retired_q + 64'(pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  // Fields kept for trace/debug but not consumed by this stage.
  always_comb begin
    unused_fields = ^head.pc;
    for (int i = 0; i < DEPTH; i++) begin
      unused_fields = unused_fields ^ (^{slots[i].wdata, slots[i].pc, slots[i].dnpc});
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.cm_valid  = ~empty;
  assign bus.cm_dnpc   = head.dnpc;
  assign bus.gpr_wen   = pop & (head.rd != '0);
  assign bus.gpr_waddr = head.rd;
  assign bus.gpr_wdata = head.wdata;
  assign bus.busy_mask = busy_mask;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_ysyx_23060203_wbu.sv
// Scoreboard bench for the write-back stage: the driver issues directed and random
// traffic, a negedge monitor compares every retire against a queue-based model.
module tb_ysyx_23060203_wbu;
  import ysyx_23060203_pkg::*;

  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;

  ysyx_23060203_wbu_if bus ();

  ysyx_23060203_wbu #(.DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned     rd;
    longint unsigned wdata;
    longint unsigned dnpc;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            e;
  int              total = 0;
  int              bad = 0;
  longint unsigned exp_retired = 0;
  int              wen_seen = 0;
  logic            obs_wen;
  logic [3:0]      obs_waddr;
  logic [31:0]     obs_wdata;
  logic [31:0]     obs_dnpc;
  int              n;
  bit              do_push, do_pop, exp_wen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference write-data rule stated in plain arithmetic.
  function automatic longint unsigned ref_wdata(input int unsigned wsel,
      input longint unsigned alu, input longint unsigned load,
      input longint unsigned csr, input longint unsigned pc);
    case (wsel)
      0:       return alu;
      1:       return load;
      2:       return (pc + 4) % 64'h1_0000_0000;
      default: return csr;
    endcase
  endfunction

  function automatic logic [63:0] ref_busy();
    logic [63:0] m;
    m = '0;
    foreach (exp_q[k]) m[exp_q[k].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // Monitor: inputs change just after posedge, so negedge sees what the next edge will act on.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_cm_valid", bus.cm_valid, 0);
        chk("rst_busy_mask", bus.busy_mask, 0);
        chk("rst_retired", bus.retired, 0);
        chk("rst_gpr_wen", bus.gpr_wen, 0);
        exp_q.delete();
        exp_retired = 0;
      end else begin
        if (bus.gpr_wen) wen_seen++;
        n       = exp_q.size();
        do_push = bus.in_valid && (n < DEPTH);
        do_pop  = (n != 0) && bus.cm_ready;
        exp_wen = 1'b0;
        if (do_pop) exp_wen = (exp_q[0].rd != 0);
        chk("cm_valid", bus.cm_valid, n != 0);
        chk("in_ready", bus.in_ready, n < DEPTH);
        chk("busy_mask", bus.busy_mask, ref_busy());
        chk("retired", bus.retired, exp_retired);
        chk("gpr_wen", bus.gpr_wen, exp_wen);
        if (n != 0) chk("cm_dnpc", bus.cm_dnpc, exp_q[0].dnpc);
        if (do_pop) begin
          e = exp_q.pop_front();
          if (e.rd != 0) begin
            chk("gpr_waddr", bus.gpr_waddr, e.rd);
            chk("gpr_wdata", bus.gpr_wdata, e.wdata);
          end
          obs_wen   = bus.gpr_wen;
          obs_waddr = bus.gpr_waddr;
          obs_wdata = bus.gpr_wdata;
          obs_dnpc  = bus.cm_dnpc;
          exp_retired++;
          $display("retire rd=%0d wdata=0x%08h dnpc=0x%08h", e.rd, e.wdata, e.dnpc);
        end
        if (do_push) begin
          exp_q.push_back('{rd: bus.in_rd,
                            wdata: ref_wdata(bus.in_wsel, bus.in_alu_val, bus.in_load,
                                             bus.in_csr_val, bus.in_pc),
                            dnpc: bus.in_dnpc});
        end
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_fields(input int rd, input int wsel, input logic [31:0] alu,
      input logic [31:0] load, input logic [31:0] csr, input logic [31:0] pc,
      input logic [31:0] dnpc);
    bus.in_rd      = 4'(rd);
    bus.in_wsel    = wsel_t'(2'(wsel));
    bus.in_alu_val = alu;
    bus.in_load    = load;
    bus.in_csr_val = csr;
    bus.in_pc      = pc;
    bus.in_dnpc    = dnpc;
  endtask

  task automatic push(input int rd, input int wsel, input logic [31:0] alu,
      input logic [31:0] load, input logic [31:0] csr, input logic [31:0] pc,
      input logic [31:0] dnpc);
    int w;
    w = 0;
    set_fields(rd, wsel, alu, load, csr, pc, dnpc);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("push_wait_expired", w >= 50, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic rand_fields();
    set_fields($urandom_range(0, 15), $urandom_range(0, 3), $urandom, $urandom,
               $urandom, (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom), $urandom);
  endtask

  initial begin
    longint unsigned base;
    int              ws;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.cm_ready = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    cyc(3);
    rst_n = 1'b1;
    chk("init_in_ready", bus.in_ready, 1);
    chk("init_cm_valid", bus.cm_valid, 0);

    // Single load retire.
    bus.cm_ready = 1'b1;
    push(5, 1, 32'h1111, 32'hDEAD_BEEF, 32'h2222, 32'h8000_0000, 32'h8000_0004);
    cyc(1);
    chk("t2_wen", obs_wen, 1);
    chk("t2_waddr", obs_waddr, 5);
    chk("t2_wdata", obs_wdata, 32'hDEAD_BEEF);
    chk("t2_dnpc", obs_dnpc, 32'h8000_0004);
    chk("t2_retired", bus.retired, 1);

    // Backpressure: fill, then drain in order.
    bus.cm_ready = 1'b0;
    push(3, 0, 32'h33, 0, 0, 32'h100, 32'h104);
    push(7, 3, 0, 0, 32'h77, 32'h104, 32'h108);
    chk("t3_in_ready_full", bus.in_ready, 0);
    chk("t3_busy_mask", bus.busy_mask, 16'h0088);
    bus.cm_ready = 1'b1;
    cyc(1);
    chk("t3_first_rd", obs_waddr, 3);
    chk("t3_in_ready_after_pop", bus.in_ready, 1);
    cyc(1);
    chk("t3_second_rd", obs_waddr, 7);
    chk("t3_second_wdata", obs_wdata, 32'h77);

    // rd == 0 commits without a register write.
    bus.cm_ready = 1'b0;
    push(0, 0, 32'h1234, 0, 0, 32'h200, 32'h204);
    chk("t4_busy_mask", bus.busy_mask, 0);
    chk("t4_cm_valid", bus.cm_valid, 1);
    base = exp_retired;
    bus.cm_ready = 1'b1;
    cyc(1);
    chk("t4_retired", bus.retired, base + 1);
    chk("t4_wen", obs_wen, 0);

    // jal at the top of the address space: pc+4 wraps to zero.
    push(1, 2, 32'h5555, 0, 0, 32'hFFFF_FFFC, 32'h0000_0040);
    cyc(1);
    chk("t5_waddr", obs_waddr, 1);
    chk("t5_wdata", obs_wdata, 0);

    // Reset with two entries queued.
    bus.cm_ready = 1'b0;
    push(9, 0, 32'h99, 0, 0, 32'h300, 32'h304);
    push(10, 1, 0, 32'hAA, 0, 32'h304, 32'h308);
    ws    = wen_seen;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    chk("t1_cm_valid", bus.cm_valid, 0);
    chk("t1_busy_mask", bus.busy_mask, 0);
    chk("t1_retired", bus.retired, 0);
    bus.cm_ready = 1'b1;
    cyc(3);
    chk("t1_no_wen_pulse", wen_seen, ws);

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.cm_ready = ($urandom_range(0, 2) != 0);
      if (i == 200) rst_n = 1'b0;
      if (i == 202) rst_n = 1'b1;
      cyc(1);
    end
    bus.in_valid = 1'b0;
    bus.cm_ready = 1'b1;
    cyc(4);
    chk("drain_cm_valid", bus.cm_valid, 0);

    // Streaming: one retire per cycle.
    base = exp_retired;
    for (int i = 0; i < 100; i++) begin
      rand_fields();
      bus.in_valid = 1'b1;
      chk("t6_in_ready", bus.in_ready, 1);
      cyc(1);
    end
    bus.in_valid = 1'b0;
    cyc(1);
    chk("t6_retired", bus.retired, base + 100);
    chk("t6_cm_valid", bus.cm_valid, 0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
